// File: rtl/calc_pkg.sv
// Shared constants for the calculator display back-end: core status codes,
// frame geometry, segment glyphs and the capture state encoding.
package calc_pkg;

  localparam int NDIG = 8;

  localparam logic [1:0] ST_ERRO  = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;

  // Active-low glyphs, dp (bit 7) always off.
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_R     = 8'hAF;
  localparam logic [7:0] SEG_O     = 8'hA3;

  typedef enum logic [0:0] {
    CAP_IDLE  = 1'b0,
    CAP_SWEEP = 1'b1
  } cap_state_e;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decode; non-decimal codes go blank.
module bcd_to_7seg
  import calc_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [7:0] seg_o
);

  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = 8'hC0;
      4'd1:    seg_o = 8'hF9;
      4'd2:    seg_o = 8'hA4;
      4'd3:    seg_o = 8'hB0;
      4'd4:    seg_o = 8'h99;
      4'd5:    seg_o = 8'h92;
      4'd6:    seg_o = 8'h82;
      4'd7:    seg_o = 8'hF8;
      4'd8:    seg_o = 8'h80;
      4'd9:    seg_o = 8'h90;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/calc_display.sv
// Captures the core's serial digit sweep into a double-buffered 8-digit frame and
// scans it onto 8 multiplexed active-low seven-segment displays (1 clock output latency).
module calc_display
  import calc_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [7:0] an,
  output logic [7:0] seg,
  output logic       frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  cap_state_e              state_q, state_d;
  logic [2:0]              exp_q, exp_d;
  logic [NDIG-1:0][3:0]    shadow_q, shadow_d;
  logic [NDIG-1:0][3:0]    disp_q, disp_d;
  logic                    done_q, commit;
  logic [PW-1:0]           presc_q, presc_d;
  logic [2:0]              scan_q, scan_d;
  logic [7:0]              an_q, an_d, seg_q, seg_d;
  logic [7:0]              glyph;
  logic [NDIG-1:0]         lz;
  logic                    lead;
  logic                    busy;

  assign busy = (status == ST_BUSY);

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    shadow_d = shadow_q;
    disp_d   = disp_q;
    commit   = 1'b0;
    case (state_q)
      CAP_IDLE: begin
        if (busy && pos == 4'd0) begin
          shadow_d[0] = data;
          exp_d       = 3'd1;
          state_d     = CAP_SWEEP;
        end
      end
      default: begin
        if (busy && pos == {1'b0, exp_q}) begin
          shadow_d[pos[2:0]] = data;
          if (pos[2:0] == 3'd7) begin
            disp_d  = shadow_d;
            commit  = 1'b1;
            exp_d   = 3'd0;
            state_d = CAP_IDLE;
          end else begin
            exp_d = exp_q + 3'd1;
          end
        end else if (busy && pos == 4'd0) begin
          // Out-of-order index 0 aborts and immediately starts a fresh sweep.
          shadow_d[0] = data;
          exp_d       = 3'd1;
        end else begin
          exp_d   = 3'd0;
          state_d = CAP_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    scan_d  = scan_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      scan_d  = scan_q + 3'd1;
    end
  end

  // Output path reads the next-state frame so a same-edge commit is shown immediately.
  bcd_to_7seg u_dec (
    .bcd_i (disp_d[scan_q]),
    .seg_o (glyph)
  );

  always_comb begin
    lz   = '0;
    lead = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      lead  = lead & (disp_d[i] == 4'd0);
      lz[i] = lead;
    end
  end

  always_comb begin
    an_d = ~(8'b1 << scan_q);
    if (status == ST_ERRO) begin
      case (scan_q)
        3'd3:    seg_d = SEG_E;
        3'd2:    seg_d = SEG_R;
        3'd1:    seg_d = SEG_R;
        3'd0:    seg_d = SEG_O;
        default: seg_d = SEG_BLANK;
      endcase
    end else if (BLANK_LZ && lz[scan_q]) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = glyph;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= CAP_IDLE;
      exp_q    <= 3'd0;
      shadow_q <= '0;
      disp_q   <= '0;
      done_q   <= 1'b0;
      presc_q  <= '0;
      scan_q   <= 3'd0;
      an_q     <= 8'hFF;
      seg_q    <= SEG_BLANK;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      done_q   <= commit;
      presc_q  <= presc_d;
      scan_q   <= scan_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_calc_display.sv
// Directed bench for calc_display: capture, abort/restart, error override, blanking and scan.
module tb_calc_display;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] status = 2'b10;
  logic [3:0] data = 4'd0;
  logic [3:0] pos = 4'd0;
  logic [7:0] an0, seg0, an1, seg1;
  logic       fd0, fd1;
  int         n_checks = 0;
  int         n_errors = 0;
  int         fd_cnt0 = 0;
  int         fd_cnt1 = 0;

  always #5 clock = ~clock;

  calc_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
    .an(an0), .seg(seg0), .frame_done(fd0)
  );

  calc_display #(.SCAN_DIV(1), .BLANK_LZ(1'b0)) dut1 (
    .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
    .an(an1), .seg(seg1), .frame_done(fd1)
  );

  always @(negedge clock) begin
    if (fd0) fd_cnt0++;
    if (fd1) fd_cnt1++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [1:0] st, input logic [3:0] p, input logic [3:0] d);
    status = st;
    pos    = p;
    data   = d;
    @(posedge clock);
    #1;
  endtask

  task automatic sweep(input logic [31:0] digs);
    for (int p = 0; p < 8; p++) step(2'b01, 4'(p), digs[4*p +: 4]);
    status = 2'b10;
  endtask

  task automatic read_digit(input int k, output logic [7:0] s);
    logic [7:0] want;
    int n;
    want = ~(8'b1 << k);
    n = 0;
    @(posedge clock);
    @(negedge clock);
    while (an0 !== want && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (n >= 40) chk("scan timeout", {24'h0, an0}, {24'h0, want});
    s = seg0;
  endtask

  task automatic chk_digit(input string tag, input int k, input logic [7:0] exp);
    logic [7:0] s;
    read_digit(k, s);
    chk(tag, {24'h0, s}, {24'h0, exp});
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] want;
    logic [7:0] exp6 [8];
    int n;
    int base;

    // 1: reset
    repeat (3) @(posedge clock);
    #1;
    chk("reset an", {24'h0, an0}, 32'hFF);
    chk("reset seg", {24'h0, seg0}, 32'hFF);
    chk("reset frame_done", {31'h0, fd0}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("first an", {24'h0, an0}, 32'hFE);
    chk("first seg", {24'h0, seg0}, 32'hC0);

    // 2: frame 3,2,1,0,...
    base = fd_cnt0;
    sweep(32'h0000_0123);
    chk("frame_done high", {31'h0, fd0}, 32'h1);
    step(2'b10, 4'd0, 4'd0);
    chk("frame_done low", {31'h0, fd0}, 32'h0);
    chk_digit("t2 d0", 0, 8'hB0);
    chk_digit("t2 d1", 1, 8'hA4);
    chk_digit("t2 d2", 2, 8'hF9);
    chk_digit("t2 d3", 3, 8'hFF);
    chk_digit("t2 d7", 7, 8'hFF);
    chk("t2 pulses", fd_cnt0 - base, 32'd1);
    @(negedge clock);
    a = an0;
    n = 0;
    while (an0 === a && n < 20) begin @(negedge clock); n++; end
    a = an0;
    n = 0;
    while (an0 === a && n < 20) begin @(negedge clock); n++; end
    chk("scan period", n, 32'd4);

    // 3: aborted sweep keeps prior frame
    sweep(32'h0000_0005);
    chk_digit("t3 prior d0", 0, 8'h92);
    base = fd_cnt0;
    for (int p = 0; p < 4; p++) step(2'b01, 4'(p), 4'd9);
    step(2'b10, 4'd4, 4'd9);
    chk_digit("t3 d0", 0, 8'h92);
    chk_digit("t3 d1", 1, 8'hFF);
    chk("t3 pulses", fd_cnt0 - base, 32'd0);

    // 4: gap aborts, restart at 0 mid-sweep, then full commit
    base = fd_cnt0;
    step(2'b01, 4'd0, 4'd1);
    step(2'b01, 4'd1, 4'd1);
    step(2'b01, 4'd2, 4'd1);
    step(2'b01, 4'd5, 4'd1);
    step(2'b01, 4'd6, 4'd1);
    step(2'b01, 4'd7, 4'd1);
    chk("t4 no commit", fd_cnt0 - base, 32'd0);
    for (int p = 0; p < 3; p++) step(2'b01, 4'(p), 4'd4);
    sweep(32'h000C_0700);
    chk_digit("t4 d0", 0, 8'hC0);
    chk_digit("t4 d1", 1, 8'hC0);
    chk_digit("t4 d2", 2, 8'hF8);
    chk_digit("t4 d3", 3, 8'hC0);
    chk_digit("t4 d4", 4, 8'hFF);
    chk_digit("t4 d5", 5, 8'hFF);
    chk("t4 pulses", fd_cnt0 - base, 32'd1);

    // 5: error override
    status = 2'b00;
    chk_digit("err d0", 0, 8'hA3);
    chk_digit("err d1", 1, 8'hAF);
    chk_digit("err d2", 2, 8'hAF);
    chk_digit("err d3", 3, 8'h86);
    chk_digit("err d4", 4, 8'hFF);
    chk_digit("err d7", 7, 8'hFF);
    status = 2'b10;
    chk_digit("post err d2", 2, 8'hF8);
    chk_digit("post err d3", 3, 8'hC0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("async reset an", {24'h0, an0}, 32'hFF);
    chk("async reset seg", {24'h0, seg0}, 32'hFF);
    @(negedge clock);
    reset = 1'b1;
    chk_digit("cleared d0", 0, 8'hC0);
    chk_digit("cleared d2", 2, 8'hFF);

    // 6: fast scan, no blanking
    base = fd_cnt1;
    sweep(32'h8765_4321);
    exp6 = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};
    @(posedge clock);
    @(negedge clock);
    n = 0;
    while (an1 !== 8'hFE && n < 16) begin @(negedge clock); n++; end
    for (int k = 0; k < 8; k++) begin
      want = ~(8'b1 << k);
      chk("t6 an", {24'h0, an1}, {24'h0, want});
      chk("t6 seg", {24'h0, seg1}, {24'h0, exp6[k]});
      @(negedge clock);
    end
    chk("t6 wrap", {24'h0, an1}, 32'hFE);
    chk("t6 pulses", fd_cnt1 - base, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
